// File: rtl/prince_sbox_cms_compress_if.sv
// Handshake and data bundle between the first CMS S-box layer, the
// refresh/compress pipeline and the PRINCE state datapath.
interface prince_sbox_cms_compress_if #(
    parameter int NCOMP = 8
);
    // Upstream side: component shares, fresh randomness and nibble tag
    logic                 in_valid;
    logic                 in_ready;
    logic [4*NCOMP-1:0]   in_comp;
    logic [4*NCOMP-1:0]   in_rnd;
    logic [3:0]           in_idx;

    // Downstream side: 2-share masked S-box output nibble
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_sh0;
    logic [3:0]           out_sh1;
    logic [3:0]           out_idx;

    // Environment view: drives the input beat and the consumer ready
    modport master (
        output in_valid,
        output in_comp,
        output in_rnd,
        output in_idx,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sh0,
        input  out_sh1,
        input  out_idx
    );

    // Pipeline view
    modport slave (
        input  in_valid,
        input  in_comp,
        input  in_rnd,
        input  in_idx,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sh0,
        output out_sh1,
        output out_idx
    );
endinterface

// File: rtl/prince_sbox_cms_compress.sv
// PRINCE CMS S-box share compression.
// Stage 1 ring-refreshes every component share with fresh randomness and
// registers it (the glitch barrier between the two CMS layers). Stage 2
// XOR-folds the lower and upper halves of each bit's components into a
// 2-share nibble. Both stages form a valid/ready pipeline that sustains
// one nibble per cycle.
module prince_sbox_cms_compress #(
    parameter int NCOMP = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    prince_sbox_cms_compress_if.slave bus
);

    localparam int W    = 4 * NCOMP;
    localparam int HALF = NCOMP / 2;

    // The share split only balances for an even component count of at least 4
    if (((NCOMP % 2) != 0) || (NCOMP < 4)) begin : g_bad_ncomp
        $error("prince_sbox_cms_compress: NCOMP must be even and >= 4");
    end

    // Ring refresh: component i absorbs r[i] and r[i+1 mod NCOMP], so each
    // random bit enters exactly twice per output bit and cancels in the
    // full XOR while every individual share is re-masked.
    function automatic logic [W-1:0] ring_refresh(
        input logic [W-1:0] comp,
        input logic [W-1:0] rnd
    );
        logic [W-1:0] res;
        res = {W{1'b0}};
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NCOMP; i++) begin
                res[b*NCOMP + i] = comp[b*NCOMP + i]
                                 ^ rnd[b*NCOMP + i]
                                 ^ rnd[b*NCOMP + ((i + 1) % NCOMP)];
            end
        end
        return res;
    endfunction

    // Fold one half (offset 0 or HALF) of every bit's components into a nibble
    function automatic logic [3:0] fold_half(
        input logic [W-1:0] shares,
        input int           offset
    );
        logic [3:0] res;
        res = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            res[b] = ^shares[b*NCOMP + offset +: HALF];
        end
        return res;
    endfunction

    // Stage 1 state
    logic [W-1:0] r1_r;
    logic [3:0]   idx1_r;
    logic         v1_r;

    // Stage 2 state (drives the outputs directly)
    logic [3:0]   sh0_r;
    logic [3:0]   sh1_r;
    logic [3:0]   oidx_r;
    logic         ovalid_r;

    // Handshake enables
    logic         en1_s;
    logic         en2_s;
    logic         in_ready_s;

    // Stage enables: stage 2 moves when its slot is free or being drained,
    // stage 1 accepts when it is empty or emptying into stage 2.
    always_comb begin
        en2_s      = v1_r & (~ovalid_r | bus.out_ready);
        in_ready_s = ~v1_r | en2_s;
        en1_s      = bus.in_valid & in_ready_s;
    end

    // Stage 1: capture refreshed shares and tag; randomness is consumed only here
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_r   <= {W{1'b0}};
            idx1_r <= 4'd0;
            v1_r   <= 1'b0;
        end else begin
            if (en1_s) begin
                r1_r   <= ring_refresh(bus.in_comp, bus.in_rnd);
                idx1_r <= bus.in_idx;
            end
            if (en1_s) begin
                v1_r <= 1'b1;
            end else if (en2_s) begin
                v1_r <= 1'b0;
            end else begin
                v1_r <= v1_r;
            end
        end
    end

    // Stage 2: compress stage-1 flops into two output shares
    always_ff @(posedge clk) begin
        if (rst) begin
            sh0_r    <= 4'd0;
            sh1_r    <= 4'd0;
            oidx_r   <= 4'd0;
            ovalid_r <= 1'b0;
        end else begin
            if (en2_s) begin
                sh0_r  <= fold_half(r1_r, 0);
                sh1_r  <= fold_half(r1_r, HALF);
                oidx_r <= idx1_r;
            end
            if (en2_s) begin
                ovalid_r <= 1'b1;
            end else if (ovalid_r & bus.out_ready) begin
                ovalid_r <= 1'b0;
            end else begin
                ovalid_r <= ovalid_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = ovalid_r;
    assign bus.out_sh0   = sh0_r;
    assign bus.out_sh1   = sh1_r;
    assign bus.out_idx   = oidx_r;

endmodule
